// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO read-side controller.
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BURST     = 2'd1,
      WAIT_LAST = 2'd2,
      ERROR     = 2'd3
   } rd_state_t;

   localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Small in-order skid buffer holding words returned by the FIFO read port
// until the downstream stream accepts them.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  clr_i,
   input  logic                                  push_i,
   input  logic [DATA_WIDTH-1:0]                 push_data_i,
   input  logic                                  pop_i,
   output logic [$clog2(SKID_DEPTH+1)-1:0]       count_o,
   output logic [DATA_WIDTH-1:0]                 head_o
);

   localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
   localparam int unsigned PW = $clog2(SKID_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [PW-1:0]         rd_ptr_q;
   logic [PW-1:0]         wr_ptr_q;
   logic [CW-1:0]         count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         // Simultaneous push and pop cancel out in the occupancy count.
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pops the FIFO in bursts and presents the words as a
// valid/ready stream with an end-of-burst marker and sticky underflow error.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned BURST_LEN  = 4,
   parameter bit          SOFT_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  hw_rst,
   input  logic                  sw_rst,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  err_clr,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_wr_lvl,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  err_underflow,
   output logic [15:0]           beat_cnt
);

   localparam int unsigned     LW     = ADDR_WIDTH + 1;
   localparam logic [LW-1:0]   BLEN_P = LW'(BURST_LEN);

   rd_state_t     state_q, state_d;
   logic [LW-1:0] blen_q, blen_d;
   logic [LW-1:0] issued_q, issued_d;
   logic [LW-1:0] sent_q, sent_d;
   logic          inflight_q, inflight_d;
   logic          err_q, err_d;
   logic [15:0]   beat_cnt_q, beat_cnt_d;

   logic [$clog2(SKID_DEPTH+1)-1:0] buf_cnt;
   logic [2:0]                      occ;
   logic                            pop;
   logic                            soft_clr;
   logic                            err_exit;
   logic                            buf_clr;

   assign soft_clr = SOFT_RESET && !sw_rst;
   assign err_exit = (state_q == ERROR) && err_clr && !fifo_underflow;
   assign buf_clr  = soft_clr || err_exit;

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk_i       (clk),
      .rst_ni      (hw_rst),
      .clr_i       (buf_clr),
      .push_i      (inflight_q),
      .push_data_i (fifo_rd_data),
      .pop_i       (pop),
      .count_o     (buf_cnt),
      .head_o      (m_data)
   );

   assign m_valid = (buf_cnt != '0);
   assign pop     = m_valid && m_ready;

   // Words already buffered or in flight after this cycle's pop; a new read
   // is only issued when the skid buffer is guaranteed a free slot.
   assign occ = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);

   assign fifo_rd_en = (state_q == BURST) && !fifo_empty && (issued_q < blen_q)
                       && (occ < 3'd2) && !fifo_underflow;

   assign m_last = m_valid && (state_q != ERROR) && (sent_q == blen_q - 1'b1);

   assign busy          = (state_q != IDLE);
   assign err_underflow = err_q;
   assign beat_cnt      = beat_cnt_q;

   always_comb begin
      state_d    = state_q;
      blen_d     = blen_q;
      issued_d   = issued_q + LW'(fifo_rd_en);
      sent_d     = sent_q + LW'(pop);
      inflight_d = fifo_rd_en;
      err_d      = err_q;
      beat_cnt_d = beat_cnt_q + 16'(pop);

      case (state_q)
         IDLE: begin
            if (enable) begin
               if (fifo_wr_lvl >= BLEN_P) begin
                  state_d  = BURST;
                  blen_d   = BLEN_P;
                  issued_d = '0;
                  sent_d   = '0;
               end else if (flush && fifo_wr_lvl != '0) begin
                  state_d  = BURST;
                  blen_d   = fifo_wr_lvl;
                  issued_d = '0;
                  sent_d   = '0;
               end
            end
         end
         BURST: begin
            if (issued_d == blen_q) state_d = WAIT_LAST;
         end
         WAIT_LAST: begin
            if (pop && m_last) state_d = IDLE;
         end
         ERROR: begin
            if (err_clr) begin
               state_d  = IDLE;
               blen_d   = '0;
               issued_d = '0;
               sent_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (err_clr) err_d = 1'b0;
      // Underflow dominates everything, including a coincident err_clr.
      if (fifo_underflow) begin
         err_d   = 1'b1;
         state_d = ERROR;
      end
   end

   always_ff @(posedge clk or negedge hw_rst) begin
      if (!hw_rst) begin
         state_q    <= IDLE;
         blen_q     <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
         beat_cnt_q <= '0;
      end else if (soft_clr) begin
         state_q    <= IDLE;
         blen_q     <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         blen_q     <= blen_d;
         issued_q   <= issued_d;
         sent_q     <= sent_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a queue-based FIFO model feeds the DUT and a
// scoreboard of popped words checks stream order, burst markers and counters.
module tb_fifo_rd_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          hw_rst = 1'b0;
   logic          sw_rst = 1'b1;
   logic          enable = 1'b0;
   logic          flush = 1'b0;
   logic          err_clr = 1'b0;
   logic          fifo_underflow = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_empty;
   logic [AW:0]   fifo_wr_lvl;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          err_underflow;
   logic [15:0]   beat_cnt;

   always #5 clk = ~clk;

   fifo_rd_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BURST_LEN  (BL),
      .SOFT_RESET (1'b1)
   ) dut (
      .clk            (clk),
      .hw_rst         (hw_rst),
      .sw_rst         (sw_rst),
      .enable         (enable),
      .flush          (flush),
      .err_clr        (err_clr),
      .fifo_empty     (fifo_empty),
      .fifo_wr_lvl    (fifo_wr_lvl),
      .fifo_rd_data   (fifo_rd_data),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_last         (m_last),
      .busy           (busy),
      .err_underflow  (err_underflow),
      .beat_cnt       (beat_cnt)
   );

   // FIFO model: registered read data, words popped are queued for checking.
   logic          tb_wr = 1'b0;
   logic [DW-1:0] tb_wdata = '0;
   logic [DW-1:0] fq[$];
   logic [DW-1:0] sb[$];
   logic [AW:0]   lvl_q = '0;

   assign fifo_wr_lvl = lvl_q;
   assign fifo_empty  = (lvl_q == '0);

   always @(posedge clk) begin : fifo_model
      logic [DW-1:0] w;
      if (fifo_rd_en && fq.size() != 0) begin
         w = fq.pop_front();
         fifo_rd_data <= w;
         sb.push_back(w);
      end
      if (tb_wr) fq.push_back(tb_wdata);
      lvl_q <= (AW+1)'(fq.size());
   end

   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            seg_n = 0;
   int            seg_cnt = 0;
   bit            err_mode = 1'b0;
   bit            hold = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic          hold_last = 1'b0;
   logic [15:0]   acc16 = '0;
   int            first_rd = -1;
   int            first_v = -1;
   int            rd_count = 0;
   int            max_sb = 0;
   int            en_cyc = 0;
   int            beat_cyc[64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive m_ready for the coming edge, then score the handshake.
   task automatic step(input logic rdy);
      logic [DW-1:0] exp_w;
      bit            exp_last;
      @(negedge clk);
      cyc++;
      m_ready = rdy;
      if (sb.size() > max_sb) max_sb = sb.size();
      if (fifo_rd_en) begin
         rd_count++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (hold) begin
         check("hold_valid", 32'(m_valid), 32'd1);
         check("hold_data", m_data, hold_data);
         check("hold_last", 32'(m_last), 32'(hold_last));
      end
      if (m_valid && m_ready) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_w = sb.pop_front();
            check("beat_data", m_data, exp_w);
         end
         exp_last = !err_mode && (((seg_cnt + 1) % BL) == 0 || (seg_cnt + 1) == seg_n);
         check("beat_last", 32'(m_last), 32'(exp_last));
         if (seg_cnt < 64) beat_cyc[seg_cnt] = cyc;
         seg_cnt++;
         acc16++;
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
   endtask

   task automatic preload(input int n, input logic [31:0] base, input bit rnd);
      enable = 1'b0;
      flush  = 1'b0;
      for (int i = 0; i < n; i++) begin
         tb_wr    = 1'b1;
         tb_wdata = rnd ? $urandom : base + i;
         step(1'b0);
      end
      tb_wr = 1'b0;
   endtask

   task automatic new_seg(input int n);
      seg_n   = n;
      seg_cnt = 0;
   endtask

   // mode 0/1: fixed m_ready, mode 2: random m_ready (mostly high).
   task automatic run_until(input int target, input int mode, input int budget, input string tag);
      int n = 0;
      while (seg_cnt < target && n < budget) begin
         step(mode == 2 ? ($urandom_range(0, 3) != 0) : mode[0]);
         n++;
      end
      check({tag, "_done"}, seg_cnt, target);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      repeat (3) step(1'b0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_underflow), 32'd0);
      check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
      check("rst_m_data", m_data, 32'd0);
      hw_rst = 1'b1;
      step(1'b0);

      // 1: two full bursts at full throughput
      preload(8, 32'hA0, 1'b0);
      new_seg(8);
      first_rd = -1;
      first_v  = -1;
      en_cyc   = cyc;
      enable   = 1'b1;
      run_until(8, 1, 60, "t1");
      enable = 1'b0;
      step(1'b1);
      step(1'b1);
      check("t1_first_rd", first_rd, en_cyc + 1);
      check("t1_first_valid", first_v, first_rd + 2);
      for (int k = 1; k < 8; k++)
         if (k != 4) check("t1_beat_gap", beat_cyc[k] - beat_cyc[k-1], 1);
      check("t1_beat_cnt", 32'(beat_cnt), 32'd8);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_empty", 32'(fifo_empty), 32'd1);

      // 2: back-pressure after the second beat
      preload(8, 32'hA0, 1'b0);
      new_seg(8);
      enable = 1'b1;
      run_until(2, 1, 20, "t2a");
      for (int i = 0; i < 5; i++) begin
         step(1'b0);
         check("t2_stall_data", m_data, 32'hA2);
         if (i > 0) check("t2_stall_rd_en", 32'(fifo_rd_en), 32'd0);
      end
      run_until(8, 1, 60, "t2b");
      enable = 1'b0;
      step(1'b1);
      step(1'b1);
      check("t2_busy", 32'(busy), 32'd0);
      check("t2_beat_cnt", 32'(beat_cnt), 32'(acc16));

      // 4: short FIFO without flush stays idle; 3: flush drains it
      preload(3, 32'hB0, 1'b0);
      new_seg(3);
      enable   = 1'b1;
      rd_count = 0;
      repeat (20) step(1'b1);
      check("t4_no_rd_en", rd_count, 0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_lvl", 32'(fifo_wr_lvl), 32'd3);
      flush = 1'b1;
      run_until(3, 1, 40, "t3");
      step(1'b1);
      step(1'b1);
      check("t3_empty", 32'(fifo_empty), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);

      // 5: underflow during BURST
      preload(8, 32'hC0, 1'b0);
      new_seg(8);
      enable = 1'b1;
      repeat (4) step(1'b0);
      check("t5_in_burst", 32'(busy), 32'd1);
      fifo_underflow = 1'b1;
      enable = 1'b0;
      step(1'b0);
      fifo_underflow = 1'b0;
      err_mode = 1'b1;
      check("t5_err_set", 32'(err_underflow), 32'd1);
      check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
      repeat (3) begin
         step(1'b0);
         check("t5_err_sticky", 32'(err_underflow), 32'd1);
         check("t5_rd_en_err", 32'(fifo_rd_en), 32'd0);
      end
      n = 0;
      while (m_valid && n < 10) begin
         step(1'b1);
         n++;
      end
      step(1'b0);
      check("t5_drained", 32'(m_valid), 32'd0);
      check("t5_err_busy", 32'(busy), 32'd1);
      err_clr = 1'b1;
      step(1'b0);
      err_clr = 1'b0;
      err_mode = 1'b0;
      check("t5_err_clr", 32'(err_underflow), 32'd0);
      check("t5_idle", 32'(busy), 32'd0);
      step(1'b0);
      check("t5_stay_idle", 32'(busy), 32'd0);
      new_seg(int'(fifo_wr_lvl));
      enable = 1'b1;
      flush  = 1'b1;
      run_until(seg_n, 2, 100, "t5_rest");
      step(1'b1);
      step(1'b1);
      check("t5_rest_busy", 32'(busy), 32'd0);

      // 5b: underflow while the would-be last beat is buffered
      preload(2, 32'hD0, 1'b0);
      new_seg(2);
      enable = 1'b1;
      flush  = 1'b1;
      repeat (4) step(1'b0);
      fifo_underflow = 1'b1;
      enable = 1'b0;
      step(1'b0);
      fifo_underflow = 1'b0;
      err_mode = 1'b1;
      run_until(2, 1, 10, "t5b_drain");
      step(1'b0);
      check("t5b_err", 32'(err_underflow), 32'd1);
      err_clr = 1'b1;
      step(1'b0);
      err_clr = 1'b0;
      err_mode = 1'b0;
      check("t5b_err_clr", 32'(err_underflow), 32'd0);
      check("t5b_idle", 32'(busy), 32'd0);

      // 6: asynchronous hard reset mid-burst
      preload(8, 32'hE0, 1'b0);
      new_seg(8);
      enable = 1'b1;
      flush  = 1'b1;
      n = 0;
      while (!m_valid && n < 10) begin
         step(1'b1);
         n++;
      end
      check("t6_valid_seen", 32'(m_valid), 32'd1);
      #2 hw_rst = 1'b0;
      #1;
      check("t6_async_valid", 32'(m_valid), 32'd0);
      check("t6_async_rd_en", 32'(fifo_rd_en), 32'd0);
      check("t6_async_last", 32'(m_last), 32'd0);
      check("t6_async_busy", 32'(busy), 32'd0);
      sb.delete();
      hold  = 1'b0;
      acc16 = '0;
      step(1'b1);
      hw_rst = 1'b1;
      new_seg(int'(fifo_wr_lvl));
      run_until(seg_n, 1, 80, "t6_rest");
      step(1'b1);
      step(1'b1);
      check("t6_beat_cnt", 32'(beat_cnt), 32'(acc16));
      check("t6_busy", 32'(busy), 32'd0);

      // Soft reset mid-burst
      preload(6, 32'h0, 1'b1);
      new_seg(6);
      enable = 1'b1;
      flush  = 1'b1;
      repeat (4) step(1'b1);
      sw_rst = 1'b0;
      step(1'b0);
      check("sw_busy", 32'(busy), 32'd0);
      check("sw_valid", 32'(m_valid), 32'd0);
      check("sw_beat_cnt", 32'(beat_cnt), 32'd0);
      sw_rst = 1'b1;
      sb.delete();
      hold  = 1'b0;
      acc16 = '0;
      new_seg(int'(fifo_wr_lvl));
      run_until(seg_n, 2, 100, "sw_rest");
      step(1'b1);
      step(1'b1);
      check("sw_rest_beat_cnt", 32'(beat_cnt), 32'(acc16));

      // Randomised bursts with random back-pressure
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 12);
         preload(n, 32'h0, 1'b1);
         new_seg(n);
         enable = 1'b1;
         run_until((n / BL) * BL, 2, 200, "rnd_full");
         repeat (8) step($urandom_range(0, 1) != 0);
         check("rnd_lvl", 32'(fifo_wr_lvl), n % BL);
         check("rnd_busy", 32'(busy), 32'd0);
         flush = 1'b1;
         run_until(n, 2, 200, "rnd_flush");
         step(1'b1);
         step(1'b1);
         check("rnd_beat_cnt", 32'(beat_cnt), 32'(acc16));
         check("rnd_idle", 32'(busy), 32'd0);
      end

      check("max_outstanding_le2", 32'(max_sb <= 2), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the synchronous FIFO. It pops words in bursts using the FIFO read port (rd_en, rd_data_out, fifo_empty, wr_lvl, underflow) and presents them downstream as a valid/ready stream with an end-of-burst marker. A 2-entry skid buffer absorbs the FIFO's one-cycle registered read latency so that downstream back-pressure never loses data.

Parameters:
DATA_WIDTH, 32, stream and FIFO word width
ADDR_WIDTH, 5, FIFO address width; level ports are ADDR_WIDTH+1 bits
BURST_LEN, 4, words per burst (1..2**ADDR_WIDTH)
SOFT_RESET, 1, 1 = sw_rst is honoured; 0 = sw_rst is ignored

Ports:
clk  in  1  clock
hw_rst  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous active-low soft reset, gated by SOFT_RESET
enable  in  1  permits new bursts to start
flush  in  1  permits a short burst when fewer than BURST_LEN words are stored
err_clr  in  1  single-cycle pulse that clears err_underflow and leaves ERROR
fifo_empty  in  1  from FIFO
fifo_wr_lvl  in  ADDR_WIDTH+1  FIFO occupancy
fifo_rd_data  in  DATA_WIDTH  FIFO rd_data_out (valid the cycle after rd_en)
fifo_underflow  in  1  from FIFO
fifo_rd_en  out  1  FIFO pop request
m_valid  out  1  stream data valid
m_ready  in  1  downstream accept
m_data  out  DATA_WIDTH  stream data
m_last  out  1  final beat of the burst
busy  out  1  state != IDLE
err_underflow  out  1  sticky underflow flag
beat_cnt  out  16  total beats accepted downstream, wraps

Behaviour:
- Reset values (hw_rst low, async; or sw_rst low with SOFT_RESET=1, sync): all outputs 0, state IDLE, skid buffer empty, inflight 0, issued 0.
- FSM states: IDLE, BURST, WAIT_LAST, ERROR.
- IDLE -> BURST when enable=1 and either:
  - fifo_wr_lvl >= BURST_LEN: latch blen = BURST_LEN, or
  - flush=1 and fifo_wr_lvl > 0: latch blen = fifo_wr_lvl.
- IDLE stays IDLE in all other cases.
- On entering BURST, issued and sent are cleared.
- Read issue, combinational:
  - fifo_rd_en = (state==BURST) && !fifo_empty && issued < blen && (buf_cnt + inflight - pop) < 2.
  - pop = m_valid && m_ready.
- Each rd_en increments issued.
- inflight is registered: it equals the previous cycle's fifo_rd_en.
- When inflight=1, fifo_rd_data is pushed into the skid buffer that cycle.
- Skid buffer is 2-entry, in-order.
  - m_valid = buf_cnt > 0; m_data = head entry.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - Push and pop in the same cycle leaves buf_cnt unchanged.
- m_last = m_valid && (sent == blen-1). sent increments on each pop.
- BURST -> WAIT_LAST when issued reaches blen.
- WAIT_LAST -> IDLE on the pop with m_last=1. The next burst can start on the cycle after that pop.
- Latency and throughput:
  - First rd_en is asserted the cycle after the IDLE->BURST transition.
  - First m_valid follows 2 cycles after that first rd_en.
  - With m_ready held 1, the block sustains 1 beat/cycle.
- fifo_underflow=1 in any state:
  - err_underflow set (sticky), state -> ERROR, fifo_rd_en forced 0.
  - Buffered data is still drained, but m_last is suppressed.
  - err_clr in ERROR -> IDLE with buffer and counters cleared.
  - err_clr outside ERROR: only clears err_underflow.
- enable dropping mid-burst has no effect; the current burst completes.
- beat_cnt is a 16-bit wrap-around counter: 0xFFFF + 1 -> 0x0000.
- Width rule: blen, issued and sent are all ADDR_WIDTH+1 bits wide, so blen = 2**ADDR_WIDTH is legal.

Decomposition:
- Package fifo_pkg holds:
  - enum rd_state_t {IDLE, BURST, WAIT_LAST, ERROR}
  - localparam SKID_DEPTH = 2
- One sub-module, fifo_skid_buf: the 2-entry in-order buffer with push/pop/count.
- FSM, issue logic and counters stay in fifo_rd_ctrl.

Test Plan:
1. FIFO preloaded with 0xA0..0xA7, BURST_LEN=4, enable=1, m_ready=1 -> beats A0..A7 on consecutive cycles within each burst; m_last on A3 and A7; beat_cnt=8; busy=0 at the end.
2. Same preload; m_ready=0 for 5 cycles after the A1 beat -> fifo_rd_en deasserts once buf_cnt+inflight=2; m_data holds A2; resuming gives A2..A7 in order with no loss or duplication.
3. 3 words preloaded, flush=1 -> one burst with blen=3; m_last on the third beat; fifo_empty=1 at the end; state IDLE.
4. 3 words preloaded, flush=0 -> stays IDLE; fifo_rd_en never asserts over 20 cycles.
5. fifo_underflow pulse during BURST -> err_underflow=1 next cycle and stays set; fifo_rd_en=0; err_clr pulse -> IDLE, err_underflow=0.
6. hw_rst low mid-burst with m_valid=1 -> m_valid, fifo_rd_en, m_last and busy drop to 0 without waiting for a clock edge; after release, a fresh burst starts from the FIFO's next word.
